// File: rtl/shift_right_seq.sv
// Iterative right shifter for SRL/SRA/SRLV/SRAV: moves the operand one bit per clock,
// filling with zero (logical) or the captured sign bit (arithmetic).
//
// state | meaning
// IDLE  | ready for a new operand; result register holds the last answer
// SHIFT | one bit shifted per clock, counter walks down to zero
// DONE  | single-cycle o_valid pulse with the final result
module shift_right_seq #(
    parameter int BUS_SIZE   = 32,
    parameter int SHAMT_SIZE = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [BUS_SIZE-1:0]   i_data,
    input  logic [SHAMT_SIZE-1:0] i_shamt,
    input  logic                  i_arith,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [BUS_SIZE-1:0]   o_result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_SIZE-1:0] CNT_ONE = SHAMT_SIZE'(1);

    state_t                r_state;
    logic [BUS_SIZE-1:0]   r_data;
    logic [BUS_SIZE-1:0]   r_result;
    logic [SHAMT_SIZE-1:0] r_cnt;
    logic                  r_fill;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_valid;
    logic [BUS_SIZE-1:0]   w_shifted;

    assign w_shifted = {r_fill, r_data[BUS_SIZE-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_data   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_fill   <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_data  <= i_data;
                        r_cnt   <= i_shamt;
                        r_fill  <= i_arith & i_data[BUS_SIZE-1];
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        // A zero amount skips SHIFT and publishes the operand directly.
                        if (i_shamt == '0) begin
                            r_state  <= S_DONE;
                            r_result <= i_data;
                            r_valid  <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_data <= w_shifted;
                    r_cnt  <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state  <= S_DONE;
                        r_result <= w_shifted;
                        r_valid  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_busy   = r_busy;
    assign o_valid  = r_valid;
    assign o_result = r_result;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: latency, fill behaviour, ignored starts,
// mid-shift reset and back-to-back operation.
module tb_shift_right_seq;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [31:0] i_data;
    logic [4:0]  i_shamt;
    logic        i_arith;
    logic        o_ready;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;

    int n_checks = 0;
    int n_fail   = 0;

    shift_right_seq #(.BUS_SIZE(32), .SHAMT_SIZE(5)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_data   (i_data),
        .i_shamt  (i_shamt),
        .i_arith  (i_arith),
        .o_ready  (o_ready),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    // Called at a negedge; returns at the negedge of the first IDLE cycle after DONE.
    // lat = edges after acceptance at which o_valid is first seen (-1 on timeout).
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                          output logic [31:0] res, output int lat, output int vwidth,
                          output logic busy0, output logic ready_after);
        i_data  = d;
        i_shamt = s;
        i_arith = a;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_data  = ~d;
        i_shamt = ~s;
        i_arith = ~a;
        @(negedge i_clk);
        busy0 = o_busy;
        lat   = 0;
        while (!o_valid && lat < 40) begin
            @(negedge i_clk);
            lat++;
        end
        if (!o_valid) lat = -1;
        res    = o_result;
        vwidth = 0;
        while (o_valid && vwidth < 5) begin
            vwidth++;
            @(negedge i_clk);
        end
        ready_after = o_ready;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_start = 1'b0;
        i_data  = 32'h0;
        i_shamt = 5'd0;
        i_arith = 1'b0;
        repeat (2) @(negedge i_clk);
        n_checks++;
        if (o_result !== 32'h0 || o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got result=%h valid=%b ready=%b busy=%b, want 0/0/1/0",
                     o_result, o_valid, o_ready, o_busy);
        end
        // start on the same edge as reset must be dropped
        i_start = 1'b1;
        i_data  = 32'h1234_5678;
        @(negedge i_clk);
        i_start = 1'b0;
        i_reset = 1'b0;
        begin
            int vseen = 0;
            int busy_seen = 0;
            for (int j = 0; j < 4; j++) begin
                if (o_valid) vseen++;
                if (o_busy) busy_seen++;
                @(negedge i_clk);
            end
            n_checks++;
            if (vseen !== 0 || busy_seen !== 0 || o_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_with_start: got valid_cycles=%0d busy_cycles=%0d ready=%b, want 0/0/1",
                         vseen, busy_seen, o_ready);
            end
        end
    endtask

    task automatic test_logical();
        logic [31:0] res; int lat; int vw; logic b0; logic rdy;
        run_op(32'hF0F0_F0F0, 5'd4, 1'b0, res, lat, vw, b0, rdy);
        n_checks++;
        if (res !== 32'h0F0F_0F0F) begin
            n_fail++; $display("FAIL logical_result: got %h, want 0f0f0f0f", res);
        end
        n_checks++;
        if (lat !== 4 || vw !== 1) begin
            n_fail++; $display("FAIL logical_timing: got lat=%0d width=%0d, want 4/1", lat, vw);
        end
        n_checks++;
        if (b0 !== 1'b1 || rdy !== 1'b1) begin
            n_fail++; $display("FAIL logical_handshake: got busy0=%b ready_after=%b, want 1/1", b0, rdy);
        end
    endtask

    task automatic test_arith();
        logic [31:0] res; int lat; int vw; logic b0; logic rdy;
        run_op(32'hF0F0_F0F0, 5'd4, 1'b1, res, lat, vw, b0, rdy);
        n_checks++;
        if (res !== 32'hFF0F_0F0F || lat !== 4) begin
            n_fail++; $display("FAIL arith_neg: got %h lat=%0d, want ff0f0f0f lat=4", res, lat);
        end
        run_op(32'h7000_0000, 5'd4, 1'b1, res, lat, vw, b0, rdy);
        n_checks++;
        if (res !== 32'h0700_0000) begin
            n_fail++; $display("FAIL arith_pos: got %h, want 07000000", res);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] res; int lat; int vw; logic b0; logic rdy;
        run_op(32'hDEAD_BEEF, 5'd0, 1'b0, res, lat, vw, b0, rdy);
        n_checks++;
        if (res !== 32'hDEAD_BEEF || lat !== 0 || vw !== 1) begin
            n_fail++; $display("FAIL shamt0: got %h lat=%0d width=%0d, want deadbeef 0/1", res, lat, vw);
        end
        run_op(32'h8000_0000, 5'd31, 1'b1, res, lat, vw, b0, rdy);
        n_checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 31) begin
            n_fail++; $display("FAIL shamt31_arith: got %h lat=%0d, want ffffffff 31", res, lat);
        end
        run_op(32'h8000_0000, 5'd31, 1'b0, res, lat, vw, b0, rdy);
        n_checks++;
        if (res !== 32'h0000_0001 || lat !== 31) begin
            n_fail++; $display("FAIL shamt31_logical: got %h lat=%0d, want 00000001 31", res, lat);
        end
        n_checks++;
        if (o_result !== 32'h0000_0001) begin
            n_fail++; $display("FAIL result_hold_idle: got %h, want 00000001", o_result);
        end
    endtask

    task automatic test_ignored_start();
        int vcount = 0;
        int vat = -1;
        logic [31:0] res = 32'h0;
        i_data  = 32'h0000_0100;
        i_shamt = 5'd8;
        i_arith = 1'b0;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge i_clk);
            if (o_valid) begin
                vcount++;
                vat = j;
                res = o_result;
            end
            if (j == 2) begin
                i_start = 1'b1;
                i_data  = 32'hFFFF_FFFF;
                i_shamt = 5'd1;
                i_arith = 1'b1;
            end else if (j == 3) begin
                i_start = 1'b0;
                i_data  = 32'h1234_5678;
            end
        end
        n_checks++;
        if (vcount !== 1 || vat !== 8 || res !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL ignored_start: got pulses=%0d at=%0d result=%h, want 1 at 8 result 00000001",
                     vcount, vat, res);
        end
    endtask

    task automatic test_reset_mid();
        int vcount = 0;
        logic [31:0] res; int lat; int vw; logic b0; logic rdy;
        i_data  = 32'hABCD_1234;
        i_shamt = 5'd10;
        i_arith = 1'b1;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge i_clk);
            if (o_valid) vcount++;
            if (j == 4) i_reset = 1'b1;
            if (j == 5) begin
                i_reset = 1'b0;
                n_checks++;
                if (o_result !== 32'h0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_state: got result=%h ready=%b busy=%b, want 0/1/0",
                             o_result, o_ready, o_busy);
                end
            end
        end
        n_checks++;
        if (vcount !== 0) begin
            n_fail++; $display("FAIL reset_mid_novalid: got %0d pulses, want 0", vcount);
        end
        run_op(32'h0000_0010, 5'd4, 1'b0, res, lat, vw, b0, rdy);
        n_checks++;
        if (res !== 32'h0000_0001 || lat !== 4) begin
            n_fail++; $display("FAIL reset_mid_restart: got %h lat=%0d, want 00000001 4", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; int lat; int vw; logic b0; logic rdy;
        logic [31:0] x; logic [4:0] n; logic a; logic [31:0] exp_v;
        for (int t = 0; t < 3; t++) begin
            x = $urandom;
            if (t == 0) x[31] = 1'b1;
            n = 5'($urandom_range(1, 31));
            a = (t != 1);
            exp_v = a ? 32'($signed(x) >>> n) : (x >> n);
            run_op(x, n, a, res, lat, vw, b0, rdy);
            n_checks++;
            if (res !== exp_v || lat !== int'(n) || vw !== 1) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: x=%h n=%0d arith=%b got %h lat=%0d width=%0d, want %h lat=%0d width=1",
                         t, x, n, a, res, lat, vw, exp_v, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_logical();
        test_arith();
        test_boundaries();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
